// File: rtl/stopwatch_ctrl_mc.sv
// Multi-channel stopwatch run/stop/clear/lap controller, one Moore FSM per channel.
// Optional lap feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl_mc #(
    parameter int unsigned CH         = 4,
    parameter int unsigned CLR_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   i_runstop,
    input  logic [CH-1:0]   i_clear,
    input  logic [CH-1:0]   i_lap,
    input  logic            i_all_clear,
    output logic [CH-1:0]   o_run,
    output logic [CH-1:0]   o_clear,
    output logic [CH-1:0]   o_hold,
    output logic [2*CH-1:0] o_state
);

    localparam int unsigned   CW       = $clog2(CLR_CYCLES + 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES - 1);

    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;
    localparam logic [1:0] ST_LAP   = 2'b11;

`ifdef STOPWATCH_LAP_EN
    localparam logic LAP_EN = 1'b1;
`else
    localparam logic LAP_EN = 1'b0;
`endif

    logic [1:0]    state_q [CH];
    logic [1:0]    state_d [CH];
    logic [CW-1:0] cnt_q   [CH];
    logic [CW-1:0] cnt_d   [CH];
    logic [CH-1:0] clr;
    logic [CH-1:0] lap_req;

    assign clr = i_clear | {CH{i_all_clear}};

`ifdef STOPWATCH_LAP_EN
    assign lap_req = i_lap;
`else
    logic unused_lap;
    assign lap_req    = '0;
    assign unused_lap = ^i_lap;
`endif

    always_comb begin
        for (int n = 0; n < CH; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            case (state_q[n])
                ST_STOP: begin
                    if (clr[n]) begin
                        state_d[n] = ST_CLEAR;
                        cnt_d[n]   = CLR_LOAD;
                    end else if (i_runstop[n]) begin
                        state_d[n] = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr[n]) begin
                        state_d[n] = ST_CLEAR;
                        cnt_d[n]   = CLR_LOAD;
                    end else if (i_runstop[n]) begin
                        state_d[n] = ST_STOP;
                    end else if (lap_req[n]) begin
                        state_d[n] = ST_LAP;
                    end
                end
                // Every input, including another clear, is ignored until the pulse ends.
                ST_CLEAR: begin
                    if (cnt_q[n] == '0) begin
                        state_d[n] = ST_STOP;
                    end else begin
                        cnt_d[n] = cnt_q[n] - CW'(1);
                    end
                end
                ST_LAP: begin
                    if (!LAP_EN) begin
                        state_d[n] = ST_STOP;
                    end else if (clr[n]) begin
                        state_d[n] = ST_CLEAR;
                        cnt_d[n]   = CLR_LOAD;
                    end else if (i_runstop[n]) begin
                        state_d[n] = ST_STOP;
                    end else if (lap_req[n]) begin
                        state_d[n] = ST_RUN;
                    end
                end
                default: state_d[n] = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < CH; n++) begin
                state_q[n] <= ST_STOP;
                cnt_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < CH; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    // Moore decode only: no input reaches an output without passing the state register.
    always_comb begin
        o_run   = '0;
        o_clear = '0;
        o_hold  = '0;
        o_state = '0;
        for (int n = 0; n < CH; n++) begin
            o_run[n]         = (state_q[n] == ST_RUN) | (LAP_EN & (state_q[n] == ST_LAP));
            o_clear[n]       = (state_q[n] == ST_CLEAR);
            o_hold[n]        = LAP_EN & (state_q[n] == ST_LAP);
            o_state[2*n +: 2] = state_q[n];
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl_mc.sv
// Self-checking bench for stopwatch_ctrl_mc: directed scenarios plus random pulses
// checked against a per-channel behavioural model.
module tb_stopwatch_ctrl_mc;

    localparam int CH  = 4;
    localparam int CLR = 3;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    // Model modes, valued as the external state code.
    localparam int M_STOP  = 0;
    localparam int M_RUN   = 1;
    localparam int M_CLEAR = 2;
    localparam int M_LAP   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   i_runstop = '0;
    logic [CH-1:0]   i_clear = '0;
    logic [CH-1:0]   i_lap = '0;
    logic            i_all_clear = 1'b0;
    logic [CH-1:0]   o_run;
    logic [CH-1:0]   o_clear;
    logic [CH-1:0]   o_hold;
    logic [2*CH-1:0] o_state;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode [CH];
    int m_left [CH];

    stopwatch_ctrl_mc #(
        .CH        (CH),
        .CLR_CYCLES(CLR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_runstop  (i_runstop),
        .i_clear    (i_clear),
        .i_lap      (i_lap),
        .i_all_clear(i_all_clear),
        .o_run      (o_run),
        .o_clear    (o_clear),
        .o_hold     (o_hold),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int n = 0; n < CH; n++) begin
            m_mode[n] = M_STOP;
            m_left[n] = 0;
        end
    endfunction

    function automatic void model_step(input logic [CH-1:0] rs, input logic [CH-1:0] cl,
                                       input logic [CH-1:0] lp, input logic ac);
        for (int n = 0; n < CH; n++) begin
            if (m_mode[n] == M_CLEAR) begin
                m_left[n] = m_left[n] - 1;
                if (m_left[n] == 0) m_mode[n] = M_STOP;
            end else if (cl[n] || ac) begin
                m_mode[n] = M_CLEAR;
                m_left[n] = CLR;
            end else if (rs[n]) begin
                m_mode[n] = (m_mode[n] == M_STOP) ? M_RUN : M_STOP;
            end else if (lp[n] && LAP_EN) begin
                if (m_mode[n] == M_RUN) m_mode[n] = M_LAP;
                else if (m_mode[n] == M_LAP) m_mode[n] = M_RUN;
            end
        end
    endfunction

    function automatic logic [CH-1:0] exp_run();
        for (int n = 0; n < CH; n++) exp_run[n] = (m_mode[n] == M_RUN) || (m_mode[n] == M_LAP);
    endfunction

    function automatic logic [CH-1:0] exp_clear();
        for (int n = 0; n < CH; n++) exp_clear[n] = (m_mode[n] == M_CLEAR);
    endfunction

    function automatic logic [CH-1:0] exp_hold();
        for (int n = 0; n < CH; n++) exp_hold[n] = (m_mode[n] == M_LAP);
    endfunction

    function automatic logic [2*CH-1:0] exp_state();
        for (int n = 0; n < CH; n++) exp_state[2*n +: 2] = 2'(m_mode[n]);
    endfunction

    // Apply one cycle of pulses; outputs are stable for sampling on return.
    task automatic drive(input logic [CH-1:0] rs, input logic [CH-1:0] cl,
                         input logic [CH-1:0] lp, input logic ac);
        @(negedge clk);
        i_runstop   = rs;
        i_clear     = cl;
        i_lap       = lp;
        i_all_clear = ac;
        @(posedge clk);
        model_step(rs, cl, lp, ac);
        #1;
        i_runstop   = '0;
        i_clear     = '0;
        i_lap       = '0;
        i_all_clear = 1'b0;
    endtask

    task automatic settle_all_stop();
        drive('0, '0, '0, 1'b1);
        for (int i = 0; i < CLR; i++) drive('0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_runstop   = 4'($urandom);
            i_clear     = 4'($urandom);
            i_lap       = 4'($urandom);
            i_all_clear = 1'($urandom);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({o_run, o_clear, o_hold, o_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got run=%b clear=%b hold=%b state=%b, expected all 0",
                     o_run, o_clear, o_hold, o_state);
        end
        @(negedge clk);
        i_runstop = '0; i_clear = '0; i_lap = '0; i_all_clear = 1'b0;
        rst_n = 1'b1;
        drive(4'b0001, '0, '0, 1'b0);
        n_checks++;
        if (o_run !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_run: got o_run=%b expected 0001", o_run);
        end
        n_checks++;
        if (o_state !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL reset_first_state: got o_state=%b expected 00000001", o_state);
        end
    endtask

    task automatic test_clear_width();
        settle_all_stop();
        drive(4'b0100, '0, '0, 1'b0);
        drive('0, 4'b0100, '0, 1'b0);
        for (int c = 0; c < CLR; c++) begin
            n_checks++;
            if (o_clear[2] !== 1'b1 || o_run[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_width_c%0d: got clear=%b run=%b expected clear=1 run=0",
                         c, o_clear[2], o_run[2]);
            end
            // Second clear mid-pulse must neither extend nor restart it.
            drive('0, (c == 0) ? 4'b0100 : 4'b0000, '0, 1'b0);
        end
        n_checks++;
        if (o_clear[2] !== 1'b0 || o_state[5:4] !== 2'b00 || o_run[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_width_end: got clear=%b state=%b run=%b expected 0 00 0",
                     o_clear[2], o_state[5:4], o_run[2]);
        end
    endtask

    task automatic test_priority();
        settle_all_stop();
        drive(4'b0010, '0, '0, 1'b0);
        drive(4'b0010, 4'b0010, 4'b0010, 1'b0);
        n_checks++;
        if (o_state[3:2] !== 2'b10 || o_hold[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL priority: got state=%b hold=%b expected 10 0", o_state[3:2], o_hold[1]);
        end
        for (int i = 0; i < CLR; i++) drive('0, '0, '0, 1'b0);
    endtask

    task automatic test_lap();
        settle_all_stop();
        drive(4'b0001, '0, '0, 1'b0);
        drive('0, '0, 4'b0001, 1'b0);
        n_checks++;
        if (o_hold[0] !== LAP_EN || o_run[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_enter: got hold=%b run=%b expected %b 1", o_hold[0], o_run[0], LAP_EN);
        end
        drive('0, '0, 4'b0001, 1'b0);
        n_checks++;
        if (o_hold[0] !== 1'b0 || o_run[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_release: got hold=%b run=%b expected 0 1", o_hold[0], o_run[0]);
        end
        drive('0, '0, 4'b0001, 1'b0);
        drive(4'b0001, '0, '0, 1'b0);
        n_checks++;
        if (o_hold[0] !== 1'b0 || o_run[0] !== 1'b0 || o_state[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL lap_stop: got hold=%b run=%b state=%b expected 0 0 00",
                     o_hold[0], o_run[0], o_state[1:0]);
        end
    endtask

    task automatic test_all_clear();
        settle_all_stop();
        drive(4'b1110, '0, '0, 1'b0);
        drive('0, '0, 4'b0100, 1'b0);
        drive('0, '0, '0, 1'b1);
        for (int c = 0; c < CLR; c++) begin
            n_checks++;
            if (o_clear !== 4'b1111 || o_run !== 4'b0000) begin
                n_fail++;
                $display("FAIL all_clear_c%0d: got clear=%b run=%b expected 1111 0000",
                         c, o_clear, o_run);
            end
            drive('0, '0, '0, 1'b0);
        end
        n_checks++;
        if (o_state !== '0 || o_clear !== '0) begin
            n_fail++;
            $display("FAIL all_clear_end: got state=%b clear=%b expected 0", o_state, o_clear);
        end
    endtask

    task automatic test_reset_mid_clear();
        settle_all_stop();
        drive(4'b1000, '0, '0, 1'b0);
        drive('0, 4'b1000, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        // Second cycle of the pulse: pull reset asynchronously between edges.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (o_clear !== '0 || o_state !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got clear=%b state=%b expected 0", o_clear, o_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < CLR + 1; i++) begin
            drive('0, '0, '0, 1'b0);
            n_checks++;
            if (o_clear !== '0 || o_state !== '0) begin
                n_fail++;
                $display("FAIL reset_no_resume_%0d: got clear=%b state=%b expected 0",
                         i, o_clear, o_state);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] rs, cl, lp;
        logic          ac;
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < CH; n++) begin
                rs[n] = ($urandom_range(0, 3) == 0);
                cl[n] = ($urandom_range(0, 9) == 0);
                lp[n] = ($urandom_range(0, 3) == 0);
            end
            ac = ($urandom_range(0, 39) == 0);
            drive(rs, cl, lp, ac);
            n_checks++;
            if (o_run !== exp_run() || o_clear !== exp_clear() || o_hold !== exp_hold() ||
                o_state !== exp_state()) begin
                n_fail++;
                $display("FAIL random_%0d: got run=%b clear=%b hold=%b state=%b expected %b %b %b %b",
                         i, o_run, o_clear, o_hold, o_state,
                         exp_run(), exp_clear(), exp_hold(), exp_state());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_width();
        test_priority();
        test_lap();
        test_all_clear();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
